// File: rtl/alu_logic_pkg.sv
// Shared opcode encodings and result-payload layout for the pipelined logical ALU.
package alu_logic_pkg;

   localparam logic [3:0] OP_ROL  = 4'b0100;
   localparam logic [3:0] OP_ROR  = 4'b0101;
   localparam logic [3:0] OP_SHL  = 4'b0110;
   localparam logic [3:0] OP_SHR  = 4'b0111;
   localparam logic [3:0] OP_AND  = 4'b1000;
   localparam logic [3:0] OP_OR   = 4'b1001;
   localparam logic [3:0] OP_NAND = 4'b1010;
   localparam logic [3:0] OP_NOR  = 4'b1011;
   localparam logic [3:0] OP_NOT  = 4'b1100;
   localparam logic [3:0] OP_XOR  = 4'b1101;
   localparam logic [3:0] OP_XNOR = 4'b1110;
   localparam logic [3:0] OP_ANDN = 4'b1111;

   // Flags travel below the result in every pipeline payload: {result, flags_t}.
   typedef struct packed {
      logic zero;
      logic parity;
      logic illegal;
   } flags_t;

   localparam int unsigned FLAG_W = $bits(flags_t);

   function automatic int unsigned payload_w(input int unsigned width);
      return width + FLAG_W;
   endfunction

   // Supported set is 01xx (shift/rotate) and 1xxx (bitwise).
   function automatic logic is_legal(input logic [3:0] op);
      return op[3] | (op[3:2] == 2'b01);
   endfunction

endpackage

// File: rtl/alu_pipe_slice.sv
// One valid/ready register slice; loads when empty or when its content drains this cycle.
module alu_pipe_slice #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         up_valid,
   input  logic [W-1:0] up_data,
   output logic         dn_valid,
   input  logic         dn_ready,
   output logic [W-1:0] dn_data
);

   logic open_c;
   logic load_c;

   assign open_c = !dn_valid || dn_ready;
   assign load_c = up_valid && open_c;

   // Data only changes on a real transfer, so an empty slice keeps its last payload.
   always_ff @(posedge clk) begin
      if (rst) begin
         dn_valid <= 1'b0;
         dn_data  <= '0;
      end else begin
         if (open_c) begin
            dn_valid <= up_valid;
         end
         if (load_c) begin
            dn_data <= up_data;
         end
      end
   end

endmodule

// File: rtl/alu_logic_unit.sv
// Pipelined bitwise/shift/rotate ALU with zero, parity and illegal-opcode flags.
module alu_logic_unit
   import alu_logic_pkg::*;
#(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       opcode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             parity,
   output logic             illegal
);

   localparam int unsigned SH_W = $clog2(WIDTH);
   localparam int unsigned PW   = payload_w(WIDTH);

   logic [SH_W-1:0]    sh;
   logic [2*WIDTH-1:0] rol_ext;
   logic [2*WIDTH-1:0] ror_ext;
   logic [WIDTH-1:0]   res_c;
   flags_t             flags_c;

   logic [STAGES:0]    v;
   logic [STAGES:0]    rdy_c;
   logic [PW-1:0]      d [STAGES+1];

   assign sh = b[SH_W-1:0];

   // Rotates use a doubled operand so sh == 0 needs no special case.
   always_comb begin
      rol_ext = {a, a} << sh;
      ror_ext = {a, a} >> sh;
      res_c   = '0;
      case (opcode)
         OP_AND:  res_c = a & b;
         OP_OR:   res_c = a | b;
         OP_NAND: res_c = ~(a & b);
         OP_NOR:  res_c = ~(a | b);
         OP_NOT:  res_c = ~a;
         OP_XOR:  res_c = a ^ b;
         OP_XNOR: res_c = ~(a ^ b);
         OP_ANDN: res_c = a & ~b;
         OP_ROL:  res_c = rol_ext[2*WIDTH-1:WIDTH];
         OP_ROR:  res_c = ror_ext[WIDTH-1:0];
         OP_SHL:  res_c = a << sh;
         OP_SHR:  res_c = a >> sh;
         default: res_c = '0;
      endcase
   end

   always_comb begin
      flags_c         = '0;
      flags_c.zero    = ~|res_c;
      flags_c.parity  = ^res_c;
      flags_c.illegal = !is_legal(opcode);
   end

   // Ready ripples back from the consumer: a slice is open when empty or draining.
   always_comb begin
      rdy_c         = '0;
      rdy_c[STAGES] = out_ready;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         rdy_c[k] = !v[k+1] || rdy_c[k+1];
      end
   end

   assign v[0]     = in_valid;
   assign d[0]     = {res_c, flags_c};
   assign in_ready = rdy_c[0];

   genvar k;
   generate
      for (k = 0; k < STAGES; k++) begin : g_stage
         alu_pipe_slice #(
            .W(PW)
         ) u_slice (
            .clk      (clk),
            .rst      (rst),
            .up_valid (v[k]),
            .up_data  (d[k]),
            .dn_valid (v[k+1]),
            .dn_ready (rdy_c[k+1]),
            .dn_data  (d[k+1])
         );
      end
   endgenerate

   assign out_valid                         = v[STAGES];
   assign {result, zero, parity, illegal}   = d[STAGES];

endmodule

// File: tb/tb_alu_logic_unit.sv
// Directed self-checking bench for alu_logic_unit at WIDTH=16, STAGES=2.
`timescale 1ns/1ps
module tb_alu_logic_unit;
   import alu_logic_pkg::*;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned STAGES = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  opcode;
   logic [15:0] a;
   logic [15:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] result;
   logic        zero;
   logic        parity;
   logic        illegal;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [15:0] r;
      logic        z;
      logic        p;
      logic        il;
      int          cyc;
   } obs_t;

   obs_t q[$];

   alu_logic_unit #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .parity(parity), .illegal(illegal)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Record every delivered result, sampled mid-cycle.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready)
         q.push_back('{r: result, z: zero, p: parity, il: illegal, cyc: cyc});
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic push(input logic [3:0] op, input logic [15:0] va, input logic [15:0] vb);
      int n = 0;
      in_valid = 1'b1; opcode = op; a = va; b = vb;
      @(negedge clk);
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (in_ready !== 1'b1) begin
         bad++;
         $display("FAIL push_accept: got in_ready=%b want 1 within 50 cycles", in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; opcode = 4'h0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      total++; if (result !== 16'h0000) begin bad++; $display("FAIL reset_result: got %h want 0000", result); end
      total++; if ({zero, parity, illegal} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {zero, parity, illegal}); end
   endtask

   task automatic test_basic();
      q.delete();
      out_ready = 1'b1;
      push(OP_AND, 16'hF0F0, 16'h0FF0);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early: got out_valid=%b want 0", out_valid); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL basic_latency: got out_valid=%b want 1", out_valid); end
      total++; if (result !== 16'h00F0) begin bad++; $display("FAIL basic_result: got %h want 00f0", result); end
      total++; if ({zero, parity, illegal} !== 3'b000) begin bad++; $display("FAIL basic_flags: got %b want 000", {zero, parity, illegal}); end
      repeat (3) @(posedge clk); #1;
      total++; if (q.size() !== 1) begin bad++; $display("FAIL basic_count: got %0d want 1", q.size()); end
   endtask

   task automatic test_back_to_back();
      logic [3:0]  ops [5];
      logic [15:0] exp_r [5];
      ops   = '{OP_OR, OP_NAND, OP_XOR, OP_XNOR, OP_ANDN};
      exp_r = '{16'hAAFF, 16'hFF55, 16'hAA55, 16'h55AA, 16'hAA00};
      q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 5; i++) push(ops[i], 16'hAAAA, 16'h00FF);
      repeat (STAGES + 2) @(posedge clk); #1;
      total++;
      if (q.size() !== 5) begin
         bad++; $display("FAIL b2b_count: got %0d want 5", q.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            total++;
            if (q[i].r !== exp_r[i] || q[i].il !== 1'b0) begin
               bad++; $display("FAIL b2b_result[%0d]: got %h il=%b want %h il=0", i, q[i].r, q[i].il, exp_r[i]);
            end
            if (i > 0) begin
               total++;
               if (q[i].cyc !== q[i-1].cyc + 1) begin
                  bad++; $display("FAIL b2b_gap[%0d]: got cycle %0d want %0d", i, q[i].cyc, q[i-1].cyc + 1);
               end
            end
         end
      end
   endtask

   task automatic test_shift();
      logic [3:0]  ops [6];
      logic [15:0] bs [6];
      logic [15:0] exp_r [6];
      logic        exp_p [6];
      ops   = '{OP_ROL, OP_ROR, OP_SHL, OP_SHR, OP_SHL, OP_ROR};
      bs    = '{16'd1, 16'd1, 16'd4, 16'd15, 16'h0010, 16'd4};
      exp_r = '{16'h0003, 16'hC000, 16'h0010, 16'h0001, 16'h8001, 16'h1800};
      exp_p = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      q.delete();
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) push(ops[i], 16'h8001, bs[i]);
      repeat (STAGES + 2) @(posedge clk); #1;
      total++;
      if (q.size() !== 6) begin
         bad++; $display("FAIL shift_count: got %0d want 6", q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (q[i].r !== exp_r[i] || q[i].p !== exp_p[i] || q[i].z !== 1'b0) begin
               bad++; $display("FAIL shift[%0d]: got %h p=%b z=%b want %h p=%b z=0", i, q[i].r, q[i].p, q[i].z, exp_r[i], exp_p[i]);
            end
         end
      end
   endtask

   task automatic test_illegal();
      logic [15:0] exp_r  [4];
      logic        exp_z  [4];
      logic        exp_p  [4];
      logic        exp_il [4];
      exp_r  = '{16'h1234, 16'h0000, 16'h0FF0, 16'h0000};
      exp_z  = '{1'b0, 1'b1, 1'b0, 1'b1};
      exp_p  = '{1'b1, 1'b0, 1'b0, 1'b0};
      exp_il = '{1'b0, 1'b1, 1'b0, 1'b1};
      q.delete();
      out_ready = 1'b1;
      push(OP_AND, 16'hFFFF, 16'h1234);
      push(4'b0000, 16'hDEAD, 16'hBEEF);
      push(OP_OR, 16'h00F0, 16'h0F00);
      push(4'b0011, 16'hFFFF, 16'hFFFF);
      repeat (STAGES + 2) @(posedge clk); #1;
      total++;
      if (q.size() !== 4) begin
         bad++; $display("FAIL illegal_count: got %0d want 4", q.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            total++;
            if (q[i].r !== exp_r[i] || q[i].z !== exp_z[i] || q[i].p !== exp_p[i] || q[i].il !== exp_il[i]) begin
               bad++; $display("FAIL illegal[%0d]: got %h z=%b p=%b il=%b want %h z=%b p=%b il=%b", i,
                  q[i].r, q[i].z, q[i].p, q[i].il, exp_r[i], exp_z[i], exp_p[i], exp_il[i]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int   acc = 0;
      logic rdy;
      logic exp_rdy;
      q.delete();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         in_valid = 1'b1; opcode = OP_OR; a = 16'(acc + 1); b = 16'h0000;
         @(negedge clk);
         rdy = in_ready;
         exp_rdy = (c < int'(STAGES));
         total++;
         if (rdy !== exp_rdy) begin bad++; $display("FAIL bp_in_ready[%0d]: got %b want %b", c, rdy, exp_rdy); end
         if (c >= int'(STAGES)) begin
            total++;
            if (out_valid !== 1'b1 || result !== 16'h0001) begin
               bad++; $display("FAIL bp_hold[%0d]: got v=%b %h want v=1 0001", c, out_valid, result);
            end
         end
         @(posedge clk); #1;
         if (rdy) acc++;
      end
      total++; if (acc !== int'(STAGES)) begin bad++; $display("FAIL bp_accepts: got %0d want %0d", acc, STAGES); end
      total++; if (q.size() !== 0) begin bad++; $display("FAIL bp_leak: got %0d want 0", q.size()); end
      out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_full_drain_ready: got %b want 1", in_ready); end
      for (int v = acc + 1; v <= 6; v++) push(OP_OR, 16'(v), 16'h0000);
      repeat (STAGES + 2) @(posedge clk); #1;
      total++;
      if (q.size() !== 6) begin
         bad++; $display("FAIL bp_count: got %0d want 6", q.size());
      end else begin
         for (int i = 0; i < 6; i++) begin
            total++;
            if (q[i].r !== 16'(i + 1)) begin bad++; $display("FAIL bp_order[%0d]: got %h want %h", i, q[i].r, 16'(i + 1)); end
         end
      end
   endtask

   task automatic test_reset_midflight();
      q.delete();
      out_ready = 1'b0;
      push(OP_XOR, 16'h1111, 16'h2222);
      push(OP_XNOR, 16'h0F0F, 16'h0000);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL rst_prefill: got out_valid=%b want 1", out_valid); end
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_full: got in_ready=%b want 0", in_ready); end
      rst = 1'b1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
      total++; if (result !== 16'h0000) begin bad++; $display("FAIL rst_result: got %h want 0000", result); end
      rst = 1'b0;
      out_ready = 1'b1;
      repeat (5) @(posedge clk); #1;
      total++; if (q.size() !== 0) begin bad++; $display("FAIL rst_stale: got %0d results want 0", q.size()); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_idle: got out_valid=%b want 0", out_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_shift();
      test_illegal();
      test_backpressure();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
